mmio_uart_tx: RTL

- Memory-mapped UART transmitter on the core's data bus, downstream of the store path and in parallel with Data_Memory.
- Consumes single-cycle stores (address from ALU result, data from register file port 2) and serialises bytes onto Tx_o.
- Internal FIFO decouples the non-stalling single-cycle core from the slow serial line.
- Status is readable through the load path (mux in front of MUX_ALU_OR_LOAD).

---
 rtl/mmio_uart_tx.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter sitting on the core data bus.
//
// Single-cycle stores to TXDATA are queued in a small FIFO and serialised
// 8N1 (LSB first) on Tx_o. STATUS and BAUD are readable through the load path.
//
// Register window at BASE_ADDR (word offsets, Address_i[1:0] ignored):
//   +0 TXDATA  W   push Write_Data_i[7:0]; reads 0
//   +4 STATUS  R/W bit0 busy, bit1 full, bit2 empty, bit3 overflow (W1C),
//                  bits[7:4] count (saturated at 15), bit8 parity enable
//                  (only with UART_TX_PARITY_EN)
//   +8 BAUD    R/W clocks per bit in bits[15:0] (0 behaves as 1)
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   Mem_Write_i   store strobe
//   Mem_Read_i    load strobe
//   Address_i     byte address
//   Write_Data_i  store data
//   Read_Data_o   combinational load data, 0 unless a read hits the window
//   Hit_o         combinational address decode of the 3-word window
//   Tx_o          registered serial output, idle high
//
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after the data
// bits, enabled by STATUS bit8).
//
// State table:
//   state    | meaning
//   S_IDLE   | line high; pops the FIFO head when data is queued
//   S_START  | start bit (low) for D clocks
//   S_DATA   | data bits LSB first, D clocks each
//   S_PARITY | even parity bit for D clocks (parity build only)
//   S_STOP   | stop bit (high) for D clocks

module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_Write_i,
    input  logic        Mem_Read_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_Data_i,
    output logic [31:0] Read_Data_o,
    output logic        Hit_o,
    output logic        Tx_o
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t       state, state_n;
    logic [15:0]  timer, timer_n;
    logic [15:0]  div_q, div_n;
    logic [2:0]   bit_idx, bit_idx_n;
    logic [7:0]   shift, shift_n;
    logic         par_bit, par_bit_n;
    logic         par_frame, par_frame_n;
    logic         tx_n;

    logic [7:0]   mem [FIFO_DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic [AW:0]  cnt;
    logic [31:0]  cnt_wide;
    logic [3:0]   cnt_sat;
    logic         fifo_empty, fifo_full;
    logic         push_req, push, pop;

    logic         ovf;
    logic [15:0]  baud_q;
    logic [15:0]  baud_eff;
    logic         par_en;

    logic [1:0]   offset;
    logic         wr_sel;
    logic         unused_bits;

    assign offset = Address_i[3:2];
    assign Hit_o  = (Address_i[31:4] == BASE_ADDR[31:4]) && (offset != 2'd3);
    assign wr_sel = Mem_Write_i && Hit_o;

    assign unused_bits = ^{Address_i[1:0], Write_Data_i[31:16]};

    // FIFO bookkeeping: extra pointer MSB distinguishes full from empty.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cnt        = wr_ptr - rd_ptr;
    assign cnt_wide   = 32'(cnt);
    assign cnt_sat    = (cnt_wide > 32'd15) ? 4'd15 : cnt_wide[3:0];

    assign pop      = (state == S_IDLE) && !fifo_empty;
    assign push_req = wr_sel && (offset == 2'd0);
    // A full FIFO still accepts the byte when the head leaves on the same edge.
    assign push     = push_req && (!fifo_full || pop);

    assign baud_eff = (baud_q == 16'd0) ? 16'd1 : baud_q;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    assign par_en = par_en_q;
`else
    assign par_en = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= Write_Data_i[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            baud_q <= 16'(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
            par_en_q <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_req && !push) begin
                ovf <= 1'b1;
            end else if (wr_sel && (offset == 2'd1) && Write_Data_i[3]) begin
                ovf <= 1'b0;
            end
            if (wr_sel && (offset == 2'd2)) begin
                baud_q <= Write_Data_i[15:0];
            end
`ifdef UART_TX_PARITY_EN
            if (wr_sel && (offset == 2'd1)) begin
                par_en_q <= Write_Data_i[8];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            div_q     <= 16'd1;
            bit_idx   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            par_frame <= 1'b0;
            Tx_o      <= 1'b1;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            div_q     <= div_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            par_bit   <= par_bit_n;
            par_frame <= par_frame_n;
            Tx_o      <= tx_n;
        end
    end

    // The line value registered each cycle is the output of the current state,
    // so Tx_o trails the state register by one clock.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        div_n       = div_q;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        par_bit_n   = par_bit;
        par_frame_n = par_frame;
        tx_n        = 1'b1;
        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) begin
                    shift_n     = mem[rd_ptr[AW-1:0]];
                    par_bit_n   = ^mem[rd_ptr[AW-1:0]];
                    par_frame_n = par_en;
                    div_n       = baud_eff;
                    timer_n     = baud_eff - 16'd1;
                    state_n     = S_START;
                end
            end
            S_START: begin
                tx_n = 1'b0;
                if (timer == 16'd0) begin
                    timer_n   = div_q - 16'd1;
                    bit_idx_n = 3'd0;
                    state_n   = S_DATA;
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            S_DATA: begin
                tx_n = shift[0];
                if (timer == 16'd0) begin
                    timer_n = div_q - 16'd1;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = par_frame ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            S_PARITY: begin
                tx_n = par_bit;
                if (timer == 16'd0) begin
                    timer_n = div_q - 16'd1;
                    state_n = S_STOP;
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            S_STOP: begin
                tx_n = 1'b1;
                if (timer == 16'd0) begin
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        Read_Data_o = 32'd0;
        if (Mem_Read_i && Hit_o) begin
            case (offset)
                2'd1:    Read_Data_o = {23'd0, par_en, cnt_sat, ovf, fifo_empty,
                                        fifo_full, (state != S_IDLE)};
                2'd2:    Read_Data_o = {16'd0, baud_q};
                default: Read_Data_o = 32'd0;
            endcase
        end
    end

endmodule
